// File: rtl/card_dealer_if.sv
// Request/valid bundle between the card dealer and the hand logic that consumes its cards.
// The hand logic (master) raises draw_req/shuffle; the dealer (slave) presents dealt cards and deck status.
interface card_dealer_if;
    logic       draw_req;
    logic       shuffle;
    logic       card_valid;
    logic [5:0] card_index;
    logic [3:0] card_rank;
    logic [1:0] card_suit;
    logic [3:0] card_value;
    logic       card_is_ace;
    logic [5:0] cards_left;
    logic       deck_empty;
    logic       busy;

    modport master (
        output draw_req, shuffle,
        input  card_valid, card_index, card_rank, card_suit, card_value,
               card_is_ace, cards_left, deck_empty, busy
    );

    modport slave (
        input  draw_req, shuffle,
        output card_valid, card_index, card_rank, card_suit, card_value,
               card_is_ace, cards_left, deck_empty, busy
    );
endinterface

// File: rtl/card_dealer.sv
// Deals cards from a single 52-card deck without replacement, picking a random start slot from a
// free-running Galois LFSR and probing forward to the next undealt slot.
module card_dealer #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic         clk_200Hz,
    input  logic         rst_n,
    card_dealer_if.slave bus
);

    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [5:0]  DECK_SIZE = 6'd52;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Returns {suit, rank} for a deck slot; slots are laid out suit-major, 13 ranks per suit.
    function automatic logic [5:0] split_card(input logic [5:0] idx);
        logic [1:0] s;
        logic [3:0] r;
        if (idx >= 6'd39) begin
            s = 2'd3;
            r = 4'(idx - 6'd39);
        end else if (idx >= 6'd26) begin
            s = 2'd2;
            r = 4'(idx - 6'd26);
        end else if (idx >= 6'd13) begin
            s = 2'd1;
            r = 4'(idx - 6'd13);
        end else begin
            s = 2'd0;
            r = idx[3:0];
        end
        return {s, r};
    endfunction

    function automatic logic [3:0] value_of(input logic [3:0] rank);
        logic [3:0] v;
        if (rank == 4'd0) begin
            v = 4'd11;
        end else if (rank >= 4'd9) begin
            v = 4'd10;
        end else begin
            v = rank + 4'd1;
        end
        return v;
    endfunction

    state_t      state_r, state_next;
    logic [15:0] lfsr_r;
    logic [51:0] mask_r, mask_next;
    logic [5:0]  ptr_r, ptr_next;
    logic [5:0]  cards_left_r, left_next;
    logic        deck_empty_r;
    logic        busy_r;
    logic        card_valid_r, valid_next;
    logic [5:0]  card_index_r, index_next;
    logic [3:0]  card_rank_r, rank_next;
    logic [1:0]  card_suit_r, suit_next;
    logic [3:0]  card_value_r, value_next;
    logic        card_is_ace_r, ace_next;
    logic [5:0]  cand_s;
    logic [5:0]  split_s;

    // Fold the 6-bit LFSR slice into 0..51 and decode the slot under the probe pointer.
    always_comb begin
        cand_s  = (lfsr_r[5:0] >= DECK_SIZE) ? (lfsr_r[5:0] - DECK_SIZE) : lfsr_r[5:0];
        split_s = split_card(ptr_r);
    end

    // State register.
    always_ff @(posedge clk_200Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic; shuffle overrides everything else in both states.
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE: begin
                if (bus.shuffle) begin
                    state_next = IDLE;
                end else if (bus.draw_req && (cards_left_r != 6'd0)) begin
                    state_next = SCAN;
                end else begin
                    state_next = IDLE;
                end
            end
            SCAN: begin
                if (bus.shuffle) begin
                    state_next = IDLE;
                end else if (!mask_r[ptr_r]) begin
                    state_next = IDLE;
                end else begin
                    state_next = SCAN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath/output next values: probe pointer, dealt mask, counters and the dealt card fields.
    always_comb begin
        mask_next  = mask_r;
        left_next  = cards_left_r;
        ptr_next   = ptr_r;
        valid_next = 1'b0;
        index_next = card_index_r;
        rank_next  = card_rank_r;
        suit_next  = card_suit_r;
        value_next = card_value_r;
        ace_next   = card_is_ace_r;
        case (state_r)
            IDLE: begin
                if (bus.shuffle) begin
                    mask_next = '0;
                    left_next = DECK_SIZE;
                end else if (bus.draw_req && (cards_left_r != 6'd0)) begin
                    ptr_next = cand_s;
                end else begin
                    ptr_next = ptr_r;
                end
            end
            SCAN: begin
                if (bus.shuffle) begin
                    mask_next = '0;
                    left_next = DECK_SIZE;
                end else if (!mask_r[ptr_r]) begin
                    mask_next[ptr_r] = 1'b1;
                    left_next  = cards_left_r - 6'd1;
                    valid_next = 1'b1;
                    index_next = ptr_r;
                    suit_next  = split_s[5:4];
                    rank_next  = split_s[3:0];
                    value_next = value_of(split_s[3:0]);
                    ace_next   = (split_s[3:0] == 4'd0);
                end else begin
                    ptr_next = (ptr_r == 6'd51) ? 6'd0 : (ptr_r + 6'd1);
                end
            end
            default: begin
                mask_next = '0;
                left_next = DECK_SIZE;
            end
        endcase
    end

    // Datapath registers; the LFSR advances every cycle independent of the FSM.
    always_ff @(posedge clk_200Hz or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r        <= SEED_EFF;
            mask_r        <= '0;
            ptr_r         <= 6'd0;
            cards_left_r  <= DECK_SIZE;
            deck_empty_r  <= 1'b0;
            busy_r        <= 1'b0;
            card_valid_r  <= 1'b0;
            card_index_r  <= 6'd0;
            card_rank_r   <= 4'd0;
            card_suit_r   <= 2'd0;
            card_value_r  <= 4'd0;
            card_is_ace_r <= 1'b0;
        end else begin
            lfsr_r        <= lfsr_step(lfsr_r);
            mask_r        <= mask_next;
            ptr_r         <= ptr_next;
            cards_left_r  <= left_next;
            deck_empty_r  <= (left_next == 6'd0);
            busy_r        <= (state_next != IDLE);
            card_valid_r  <= valid_next;
            card_index_r  <= index_next;
            card_rank_r   <= rank_next;
            card_suit_r   <= suit_next;
            card_value_r  <= value_next;
            card_is_ace_r <= ace_next;
        end
    end

    assign bus.card_valid  = card_valid_r;
    assign bus.card_index  = card_index_r;
    assign bus.card_rank   = card_rank_r;
    assign bus.card_suit   = card_suit_r;
    assign bus.card_value  = card_value_r;
    assign bus.card_is_ace = card_is_ace_r;
    assign bus.cards_left  = cards_left_r;
    assign bus.deck_empty  = deck_empty_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: reset, LFSR, single and back-to-back deals, wrap probing,
// shuffle priority/abort and asynchronous reset during a scan.
module tb_card_dealer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] m_lfsr;
    int          total = 0;
    int          bad = 0;

    card_dealer_if bus ();

    card_dealer #(.SEED(16'hACE1)) dut (
        .clk_200Hz (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_model(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int cand_of(input logic [15:0] v);
        int c;
        c = int'(v[5:0]);
        if (c >= 52) c = c - 52;
        return c;
    endfunction

    function automatic int exp_rank(input int i);
        return i % 13;
    endfunction

    function automatic int exp_value(input int i);
        int r;
        r = i % 13;
        if (r == 0) return 11;
        else if (r >= 9) return 10;
        else return r + 1;
    endfunction

    // Reference LFSR, reset together with the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_model(m_lfsr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // One request pulse, then wait (bounded) for the card; returns the candidate seen at the request edge.
    task automatic draw_one(output int idx, output int cand, output logic got);
        got = 1'b0;
        idx = -1;
        @(negedge clk);
        cand = cand_of(m_lfsr);
        bus.draw_req = 1'b1;
        tick();
        bus.draw_req = 1'b0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (bus.card_valid) begin
                got = 1'b1;
                idx = int'(bus.card_index);
                break;
            end
        end
    endtask

    initial begin
        int          c, idx, cand, first_idx, dealt, since, max_lat, dup, ferr, lerr, wait_n;
        logic        got, seen_valid, seen_busy;
        logic [51:0] seen;

        bus.draw_req = 1'b0;
        bus.shuffle  = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_cards_left", bus.cards_left, 52);
        chk("rst_deck_empty", bus.deck_empty, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.card_valid, 0);
        chk("rst_index", bus.card_index, 0);
        chk("rst_value", bus.card_value, 0);
        chk("rst_lfsr", dut.lfsr_r, 16'hACE1);
        @(negedge clk);
        rst_n = 1'b1;

        // LFSR: hand-stepped values ACE1 -> E270 -> 7138 -> 389C.
        tick();
        chk("lfsr_step1", dut.lfsr_r, 16'hE270);
        tick();
        tick();
        chk("lfsr_step3", dut.lfsr_r, 16'h389C);
        seen_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            seen_valid |= bus.card_valid;
        end
        chk("idle_no_valid", seen_valid, 0);
        chk("idle_cards_left", bus.cards_left, 52);
        chk("idle_busy", bus.busy, 0);
        chk("lfsr_vs_model", dut.lfsr_r, m_lfsr);

        // Single draw: valid two edges after the request edge.
        @(negedge clk);
        c = cand_of(m_lfsr);
        bus.draw_req = 1'b1;
        tick();
        bus.draw_req = 1'b0;
        chk("draw_busy_scan", bus.busy, 1);
        chk("draw_no_early_valid", bus.card_valid, 0);
        tick();
        chk("draw_valid", bus.card_valid, 1);
        chk("draw_index", bus.card_index, c);
        chk("draw_rank", bus.card_rank, exp_rank(c));
        chk("draw_suit", bus.card_suit, c / 13);
        chk("draw_value", bus.card_value, exp_value(c));
        chk("draw_ace", bus.card_is_ace, (c % 13) == 0);
        chk("draw_left", bus.cards_left, 51);
        chk("draw_busy_done", bus.busy, 0);
        tick();
        chk("draw_valid_pulse", bus.card_valid, 0);
        chk("draw_index_hold", bus.card_index, c);

        // Shuffle together with draw_req in IDLE: shuffle wins.
        @(negedge clk);
        bus.shuffle  = 1'b1;
        bus.draw_req = 1'b1;
        tick();
        bus.shuffle  = 1'b0;
        bus.draw_req = 1'b0;
        chk("shdraw_busy", bus.busy, 0);
        chk("shdraw_left", bus.cards_left, 52);
        tick();
        chk("shdraw_no_valid", bus.card_valid, 0);

        // Full deck with draw_req held high.
        do_reset();
        @(negedge clk);
        c = cand_of(m_lfsr);
        bus.draw_req = 1'b1;
        seen = '0; dealt = 0; since = 0; max_lat = 0; dup = 0; ferr = 0; lerr = 0; first_idx = -1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (dealt == 52) break;
            tick();
            since++;
            if (bus.card_valid) begin
                idx = int'(bus.card_index);
                if (dealt == 0) first_idx = idx;
                if (idx > 51 || seen[idx]) dup++;
                else seen[idx] = 1'b1;
                if (idx <= 51 && (int'(bus.card_rank) != exp_rank(idx) || int'(bus.card_suit) != idx / 13 ||
                    int'(bus.card_value) != exp_value(idx))) ferr++;
                if (int'(bus.cards_left) != 51 - dealt) lerr++;
                if (since > max_lat) max_lat = since;
                since = 0;
                dealt++;
            end
        end
        chk("full_dealt", dealt, 52);
        chk("full_first_index", first_idx, c);
        chk("full_duplicates", dup, 0);
        chk("full_all_seen", seen, 52'hF_FFFF_FFFF_FFFF);
        chk("full_fields", ferr, 0);
        chk("full_countdown", lerr, 0);
        chk("full_latency_le53", (max_lat - 1) <= 53, 1);
        chk("full_left_zero", bus.cards_left, 0);
        chk("full_deck_empty", bus.deck_empty, 1);
        seen_valid = 1'b0;
        seen_busy  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen_valid |= bus.card_valid;
            seen_busy  |= bus.busy;
        end
        bus.draw_req = 1'b0;
        chk("empty_no_valid", seen_valid, 0);
        chk("empty_no_busy", seen_busy, 0);

        // Shuffle aborting a scan after a few deals.
        @(negedge clk);
        bus.shuffle = 1'b1;
        tick();
        bus.shuffle = 1'b0;
        chk("shuf_left", bus.cards_left, 52);
        chk("shuf_empty", bus.deck_empty, 0);
        for (int i = 0; i < 3; i++) draw_one(idx, cand, got);
        chk("pre_abort_left", bus.cards_left, 49);
        @(negedge clk);
        bus.draw_req = 1'b1;
        tick();
        bus.draw_req = 1'b0;
        bus.shuffle  = 1'b1;
        chk("abort_busy", bus.busy, 1);
        tick();
        bus.shuffle = 1'b0;
        chk("abort_no_valid", bus.card_valid, 0);
        chk("abort_busy_clear", bus.busy, 0);
        chk("abort_left", bus.cards_left, 52);
        chk("abort_mask", dut.mask_r, 0);
        draw_one(idx, cand, got);
        chk("abort_next_got", got, 1);
        chk("abort_next_index", idx, cand);
        chk("abort_next_left", bus.cards_left, 51);

        // Only slot 0 free, candidate 51: probe 51, wrap, deal 0.
        do_reset();
        @(negedge clk);
        force dut.mask_r = 52'hF_FFFF_FFFF_FFFE;
        force dut.cards_left_r = 6'd1;
        @(posedge clk);
        @(negedge clk);
        release dut.mask_r;
        release dut.cards_left_r;
        wait_n = 0;
        while (m_lfsr[5:0] != 6'd51 && wait_n < 3000) begin
            @(negedge clk);
            wait_n++;
        end
        chk("wrap_cand_found", wait_n < 3000, 1);
        bus.draw_req = 1'b1;
        tick();
        bus.draw_req = 1'b0;
        chk("wrap_busy1", bus.busy, 1);
        tick();
        chk("wrap_no_valid2", bus.card_valid, 0);
        chk("wrap_busy2", bus.busy, 1);
        tick();
        chk("wrap_valid3", bus.card_valid, 1);
        chk("wrap_index", bus.card_index, 0);
        chk("wrap_ace", bus.card_is_ace, 1);
        chk("wrap_value", bus.card_value, 11);
        chk("wrap_left", bus.cards_left, 0);
        chk("wrap_empty", bus.deck_empty, 1);

        // Only slot 22 free: ten of diamonds-equivalent, rank 9 suit 1 value 10.
        do_reset();
        @(negedge clk);
        force dut.mask_r = 52'hF_FFFF_FFBF_FFFF;
        force dut.cards_left_r = 6'd1;
        @(posedge clk);
        @(negedge clk);
        release dut.mask_r;
        release dut.cards_left_r;
        draw_one(idx, cand, got);
        chk("s22_got", got, 1);
        chk("s22_index", idx, 22);
        chk("s22_rank", bus.card_rank, 9);
        chk("s22_suit", bus.card_suit, 1);
        chk("s22_value", bus.card_value, 10);
        chk("s22_ace", bus.card_is_ace, 0);

        // Asynchronous reset in the middle of a scan.
        do_reset();
        draw_one(idx, cand, got);
        @(negedge clk);
        bus.draw_req = 1'b1;
        tick();
        bus.draw_req = 1'b0;
        chk("arst_busy_before", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_valid", bus.card_valid, 0);
        chk("arst_index", bus.card_index, 0);
        chk("arst_value", bus.card_value, 0);
        chk("arst_left", bus.cards_left, 52);
        chk("arst_lfsr", dut.lfsr_r, 16'hACE1);
        #1 rst_n = 1'b1;
        tick();
        chk("arst_lost_card", bus.card_valid, 0);
        draw_one(idx, cand, got);
        chk("arst_next_got", got, 1);
        chk("arst_next_index", idx, cand);
        chk("arst_next_left", bus.cards_left, 51);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
